// File: rtl/alu_wide_sequencer.sv
// Sequences one wide operation through a shared 4-bit registered ALU, LS nibble first.
// The carry out of each nibble becomes the carry in of the next nibble.
//
// state  | meaning
// IDLE   | ready for a request, ALU drive parked at zero
// ISSUE  | present nibble idx to the ALU, which captures it at the end of the cycle
// WAIT   | ALU output holds nibble idx result; merge it and advance or finish
// RESP   | wide result valid, held until the consumer accepts it
module alu_wide_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_sel,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_f,
  output logic         rsp_cout,
  output logic [2:0]   alu_sel,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cin,
  input  logic [3:0]   alu_f,
  input  logic         alu_cout
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [2:0]     r_sel;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_rsp_f;
  logic           r_rsp_cout;
  logic           r_rsp_valid;

  logic [3:0]     w_nib_a;
  logic [3:0]     w_nib_b;
  logic [W-1:0]   w_res_merged;
  logic           w_last;

  assign w_last    = (r_idx == IW'(NIBBLES - 1));
  assign rsp_valid = r_rsp_valid;
  assign rsp_f     = r_rsp_f;
  assign rsp_cout  = r_rsp_cout;

  // Nibble select and result merge use constant slices so only one nibble is ever touched.
  always_comb begin
    w_nib_a      = 4'd0;
    w_nib_b      = 4'd0;
    w_res_merged = r_res;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib_a                  = r_a[4*k +: 4];
        w_nib_b                  = r_b[4*k +: 4];
        w_res_merged[4*k +: 4]   = alu_f;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    alu_sel   = 3'd0;
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    alu_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_sel = r_sel;
        alu_a   = w_nib_a;
        alu_b   = w_nib_b;
        alu_cin = r_carry;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        alu_sel = r_sel;
        alu_a   = w_nib_a;
        alu_b   = w_nib_b;
        alu_cin = r_carry;
        w_next  = w_last ? S_RESP : S_ISSUE;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel       <= 3'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_res       <= '0;
      r_rsp_f     <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sel   <= req_sel;
            r_a     <= req_a;
            r_b     <= req_b;
            r_carry <= req_cin;
            r_idx   <= '0;
            r_res   <= '0;
          end
        end
        S_WAIT: begin
          r_res   <= w_res_merged;
          r_carry <= alu_cout;
          if (w_last) begin
            r_rsp_f     <= w_res_merged;
            r_rsp_cout  <= alu_cout;
            r_rsp_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
